aurora_os_serializer: RTL and testbench
=======================================

AURORA_OS_SERIALIZER -- requirements
Module: aurora_os_serializer

Interface
REQ-001 The block SHALL have parameter LFSR_SEED, default 7'h01, the idle LFSR value loaded at reset; a value of 0 is illegal.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1, marking an ordered-set request as valid.
REQ-005 The block SHALL have port req_os, input, ordered_sets_e, the requested ordered set.
REQ-006 The block SHALL have port req_ready, output, 1, marking that the block accepts the request.
REQ-007 The block SHALL have port tx_data, output, 8, the character byte for the 8b/10b encoder (HGF_EDCBA).
REQ-008 The block SHALL have port tx_is_k, output, 1, marking tx_data as a K-character.
REQ-009 The block SHALL have port tx_valid, output, 1, marking tx_data/tx_is_k as valid.
REQ-010 The block SHALL have port tx_ready, input, 1, the encoder's acceptance of the byte.
REQ-011 The block SHALL have port tx_last, output, 1, marking the final byte of the current ordered set.

Function
REQ-012 A request SHALL be accepted on a cycle where req_valid && req_ready; a byte SHALL be transferred on a cycle where tx_valid && tx_ready.
REQ-013 The block SHALL implement an FSM with states S_IDLE and S_EMIT: S_IDLE->S_EMIT on acceptance of a set of length >0; S_EMIT->S_IDLE on transfer of the last byte with no new acceptance.
REQ-014 Set length SHALL be 4 for SP, SPA, VER and I; 2 for SCP, ECP and CC; 1 for P_SUF, K, R, A and SNF; 0 for NONE and for any unlisted encoding.
REQ-015 Bytes SHALL be emitted least-significant byte first (bits 7:0 first), one per transfer.
REQ-016 tx_is_k SHALL be 1 for byte 0 of SP, SPA and VER, and for every emitted byte of SCP, ECP, CC, P_SUF, K, R, A and SNF; it SHALL be 0 for bytes 1-3 of SP, SPA and VER.
REQ-017 For I, each byte SHALL come from the idle LFSR: lfsr[1:0]=00 or 01 gives K28.5 (8'hBC), 10 gives K28.0 (8'h1C), 11 gives K28.3 (8'h7C); tx_is_k=1 for every idle byte.
REQ-018 The idle LFSR SHALL be 7-bit, with fb = lfsr[6]^lfsr[5] and next state = {lfsr[5:0],fb}; it SHALL advance only on transfer of an idle byte.
REQ-019 Accepted bytes SHALL be latched into a 32-bit holding register and walked with a 2-bit byte counter; req_os SHALL NOT be sampled after acceptance.
REQ-020 req_ready SHALL be 1 in S_IDLE, and in S_EMIT only on the cycle the last byte transfers (tx_valid && tx_ready && tx_last), giving zero-bubble back-to-back sets.
REQ-021 A length-0 request SHALL be accepted in S_IDLE, SHALL produce no bytes and SHALL leave the state in S_IDLE.
REQ-022 If a length-0 request is accepted on the last-byte cycle, the state SHALL go to S_IDLE.
REQ-023 tx_valid SHALL be registered; the first byte of an accepted set SHALL appear one cycle after acceptance.
REQ-024 While tx_valid=1 && tx_ready=0, tx_data, tx_is_k and tx_last SHALL be held stable.
REQ-025 tx_last SHALL be 1 exactly on the final byte of each set; for sets of length 1, every byte SHALL carry tx_last=1.

Reset
REQ-026 While rst=1, the block SHALL force tx_valid=0, tx_data=0, tx_is_k=0, tx_last=0, req_ready=0, state=S_IDLE, byte counter=0 and lfsr=LFSR_SEED.
REQ-027 Reset asserted mid-set SHALL abort the set with no further bytes emitted; req_ready SHALL rise on the first cycle after rst deasserts.

Structure
REQ-028 Functions os_len(ordered_sets_e) returning 3 bits and os_kmask(ordered_sets_e) returning 4 bits SHALL reside in aurora_pkg.
REQ-029 Constants IDLE_LFSR_W=7 and the character constants K28_5, K28_0 and K28_3 SHALL reside in aurora_pkg.
REQ-030 The idle LFSR SHALL be a separate sub-module, aurora_idle_lfsr, with ports clk, rst, advance, seed and lfsr.

Verification
REQ-031 Bench SHALL drive SP with tx_ready=1 and check bytes BC/1, 4A/0, 4A/0, 4A/0 (data/is_k), with tx_last only on byte 3.
REQ-032 Bench SHALL drive SCP then ECP back-to-back and check 5C/1, FB/1(last), FD/1, FE/1(last) with no idle cycle between the sets.
REQ-033 Bench SHALL drive I after reset with the default seed and check BC, 1C, BC, BC, all with is_k=1.
REQ-034 Bench SHALL send VER while holding tx_ready=0 for 3 cycles on byte 1 and check that E8/0 stays stable and no byte is lost or duplicated.
REQ-035 Bench SHALL assert rst during byte 2 of SPA and check that tx_valid=0 the next cycle and that a following K request yields a single BC/1 with tx_last=1.
REQ-036 Bench SHALL send NONE and check that it is accepted in one cycle with tx_valid staying 0.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared types, character constants and ordered-set lookup helpers for the
// Aurora 8b/10b ordered-set path.
package aurora_pkg;

    localparam int unsigned IDLE_LFSR_W = 7;

    // Idle K-characters.
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;

    // Other characters used by ordered sets.
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] D10_2 = 8'h4A;
    localparam logic [7:0] D12_1 = 8'h2C;
    localparam logic [7:0] D8_7  = 8'hE8;

    typedef enum logic [3:0] {
        OS_NONE  = 4'd0,
        OS_SP    = 4'd1,
        OS_SPA   = 4'd2,
        OS_VER   = 4'd3,
        OS_I     = 4'd4,
        OS_SCP   = 4'd5,
        OS_ECP   = 4'd6,
        OS_CC    = 4'd7,
        OS_P_SUF = 4'd8,
        OS_K     = 4'd9,
        OS_R     = 4'd10,
        OS_A     = 4'd11,
        OS_SNF   = 4'd12
    } ordered_sets_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } os_state_e;

    // Number of bytes in an ordered set; 0 means nothing is emitted.
    function automatic logic [2:0] os_len(input ordered_sets_e os);
        case (os)
            OS_SP, OS_SPA, OS_VER, OS_I:                 os_len = 3'd4;
            OS_SCP, OS_ECP, OS_CC:                       os_len = 3'd2;
            OS_P_SUF, OS_K, OS_R, OS_A, OS_SNF:          os_len = 3'd1;
            default:                                     os_len = 3'd0;
        endcase
    endfunction

    // Per-byte K flag, bit n belongs to byte n.
    function automatic logic [3:0] os_kmask(input ordered_sets_e os);
        case (os)
            OS_SP, OS_SPA, OS_VER:                       os_kmask = 4'b0001;
            OS_I:                                        os_kmask = 4'b1111;
            OS_SCP, OS_ECP, OS_CC:                       os_kmask = 4'b0011;
            OS_P_SUF, OS_K, OS_R, OS_A, OS_SNF:          os_kmask = 4'b0001;
            default:                                     os_kmask = 4'b0000;
        endcase
    endfunction

    // Character bytes, byte 0 in bits 7:0. Idle bytes come from the LFSR
    // instead, so I has no fixed pattern here.
    function automatic logic [31:0] os_bytes(input ordered_sets_e os);
        case (os)
            OS_SP:    os_bytes = {D10_2, D10_2, D10_2, K28_5};
            OS_SPA:   os_bytes = {D12_1, D12_1, D12_1, K28_5};
            OS_VER:   os_bytes = {D8_7,  D8_7,  D8_7,  K28_5};
            OS_SCP:   os_bytes = {16'h0000, K27_7, K28_2};
            OS_ECP:   os_bytes = {16'h0000, K30_7, K29_7};
            OS_CC:    os_bytes = {16'h0000, K23_7, K23_7};
            OS_P_SUF: os_bytes = {24'h000000, K28_4};
            OS_K:     os_bytes = {24'h000000, K28_5};
            OS_R:     os_bytes = {24'h000000, K28_0};
            OS_A:     os_bytes = {24'h000000, K28_3};
            OS_SNF:   os_bytes = {24'h000000, K28_6};
            default:  os_bytes = '0;
        endcase
    endfunction

    // Idle character selected by the two LSBs of the idle LFSR.
    function automatic logic [7:0] idle_char(input logic [1:0] sel);
        case (sel)
            2'b10:   idle_char = K28_0;
            2'b11:   idle_char = K28_3;
            default: idle_char = K28_5;
        endcase
    endfunction

endpackage

// File: rtl/aurora_idle_lfsr.sv
// 7-bit idle-sequence LFSR; steps once per transferred idle byte.
module aurora_idle_lfsr
    import aurora_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   advance,
    input  logic [IDLE_LFSR_W-1:0] seed,
    output logic [IDLE_LFSR_W-1:0] lfsr
);

    logic fb;

    assign fb = lfsr[IDLE_LFSR_W-1] ^ lfsr[IDLE_LFSR_W-2];

    // Load the seed on reset, otherwise shift left with feedback into bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= seed;
        end else if (advance) begin
            lfsr <= {lfsr[IDLE_LFSR_W-2:0], fb};
        end
    end

endmodule

// File: rtl/aurora_os_serializer.sv
// Ordered-set serializer: accepts one ordered-set request and streams its
// character bytes, LSB first, to the 8b/10b encoder with valid/ready.
module aurora_os_serializer
    import aurora_pkg::*;
#(
    parameter logic [IDLE_LFSR_W-1:0] LFSR_SEED = 7'h01
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  ordered_sets_e req_os,
    output logic          req_ready,
    output logic [7:0]    tx_data,
    output logic          tx_is_k,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          tx_last
);

    os_state_e              state;
    os_state_e              state_d;
    logic [31:0]            hold;
    logic [3:0]             kmask;
    logic [2:0]             len;
    logic [1:0]             cnt;
    logic                   is_idle;
    logic [IDLE_LFSR_W-1:0] lfsr;
    logic [2:0]             req_len;
    logic                   accept;
    logic                   xfer;
    logic                   xfer_last;
    logic [7:0]             cur_byte;

    assign req_len   = os_len(req_os);
    assign xfer      = tx_valid && tx_ready;
    assign xfer_last = xfer && tx_last;
    // Ready on the last-byte cycle too, so the next set follows with no bubble.
    assign req_ready = !rst && ((state == S_IDLE) || xfer_last);
    assign accept    = req_valid && req_ready;
    // tx_valid is a decode of the state register, so it is registered.
    assign tx_valid  = (state == S_EMIT);

    aurora_idle_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (xfer && is_idle),
        .seed    (LFSR_SEED),
        .lfsr    (lfsr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state: emit while a non-empty set is loaded.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept && (req_len != 3'd0)) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (xfer_last) begin
                    state_d = (accept && (req_len != 3'd0)) ? S_EMIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latch the set on acceptance, then step the byte counter per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold    <= '0;
            kmask   <= '0;
            len     <= '0;
            cnt     <= '0;
            is_idle <= 1'b0;
        end else if (accept && (req_len != 3'd0)) begin
            hold    <= os_bytes(req_os);
            kmask   <= os_kmask(req_os);
            len     <= req_len;
            cnt     <= '0;
            is_idle <= (req_os == OS_I);
        end else if (xfer && !tx_last) begin
            cnt <= cnt + 2'd1;
        end
    end

    // Present the current byte; idle bytes track the LFSR, which only moves
    // on a transfer, so outputs hold still while the encoder stalls.
    always_comb begin
        tx_data = '0;
        tx_is_k = 1'b0;
        tx_last = 1'b0;
        case (cnt)
            2'd0:    cur_byte = hold[7:0];
            2'd1:    cur_byte = hold[15:8];
            2'd2:    cur_byte = hold[23:16];
            default: cur_byte = hold[31:24];
        endcase
        if (tx_valid) begin
            tx_data = is_idle ? idle_char(lfsr[1:0]) : cur_byte;
            tx_is_k = kmask[cnt];
            tx_last = ({1'b0, cnt} == (len - 3'd1));
        end
    end

endmodule

// File: tb/tb_aurora_os_serializer.sv
// Directed self-checking bench for aurora_os_serializer.
module tb_aurora_os_serializer;
    import aurora_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    ordered_sets_e req_os;
    logic          req_ready;
    logic [7:0]    tx_data;
    logic          tx_is_k;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_last;

    int n_tests = 0;
    int n_fail  = 0;

    aurora_os_serializer #(.LFSR_SEED(7'h01)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_os    (req_os),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_is_k   (tx_is_k),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted.
    task automatic send(input ordered_sets_e os);
        int n;
        req_os    = os;
        req_valid = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("req_timeout", 32'd0, 32'd1);
        tick();
        req_valid = 1'b0;
        req_os    = OS_R;   // must not be re-sampled after acceptance
    endtask

    // Wait for the next transfer, check it, then let it happen.
    task automatic expect_byte(input string tag, input logic [7:0] d,
                               input logic k, input logic l);
        int n;
        n = 0;
        while (!(tx_valid && tx_ready) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_data"}, {24'd0, tx_data}, {24'd0, d});
        check({tag, "_isk"},  {31'd0, tx_is_k}, {31'd0, k});
        check({tag, "_last"}, {31'd0, tx_last}, {31'd0, l});
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_os    = OS_NONE;
        tx_ready  = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_data",  {24'd0, tx_data}, 32'd0);
        check("rst_last",  {31'd0, tx_last}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Idle sequence from seed 01: 01->02->04->08 gives BC 1C BC BC.
        send(OS_I);
        expect_byte("i0", 8'hBC, 1'b1, 1'b0);
        expect_byte("i1", 8'h1C, 1'b1, 1'b0);
        expect_byte("i2", 8'hBC, 1'b1, 1'b0);
        expect_byte("i3", 8'hBC, 1'b1, 1'b1);
        check("i_done_valid", {31'd0, tx_valid}, 32'd0);

        // SP.
        send(OS_SP);
        check("sp_first_latency", {31'd0, tx_valid}, 32'd1);
        expect_byte("sp0", 8'hBC, 1'b1, 1'b0);
        expect_byte("sp1", 8'h4A, 1'b0, 1'b0);
        expect_byte("sp2", 8'h4A, 1'b0, 1'b0);
        expect_byte("sp3", 8'h4A, 1'b0, 1'b1);
        check("sp_done_valid", {31'd0, tx_valid}, 32'd0);

        // SCP then ECP back-to-back, ECP waiting while SCP drains.
        send(OS_SCP);
        req_os    = OS_ECP;
        req_valid = 1'b1;
        #1;
        check("scp_ready_b0", {31'd0, req_ready}, 32'd0);
        expect_byte("scp0", 8'h5C, 1'b1, 1'b0);
        check("scp_ready_last", {31'd0, req_ready}, 32'd1);
        expect_byte("scp1", 8'hFB, 1'b1, 1'b1);
        req_valid = 1'b0;
        req_os    = OS_R;
        check("ecp_no_bubble", {31'd0, tx_valid}, 32'd1);
        expect_byte("ecp0", 8'hFD, 1'b1, 1'b0);
        expect_byte("ecp1", 8'hFE, 1'b1, 1'b1);
        check("ecp_done_valid", {31'd0, tx_valid}, 32'd0);

        // VER with a 3-cycle stall on byte 1.
        send(OS_VER);
        expect_byte("ver0", 8'hBC, 1'b1, 1'b0);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ver_stall_valid", {31'd0, tx_valid}, 32'd1);
            check("ver_stall_data",  {24'd0, tx_data}, 32'h0000_00E8);
            check("ver_stall_isk",   {31'd0, tx_is_k}, 32'd0);
            check("ver_stall_last",  {31'd0, tx_last}, 32'd0);
            tick();
        end
        tx_ready = 1'b1;
        #1;
        expect_byte("ver1", 8'hE8, 1'b0, 1'b0);
        expect_byte("ver2", 8'hE8, 1'b0, 1'b0);
        expect_byte("ver3", 8'hE8, 1'b0, 1'b1);
        check("ver_done_valid", {31'd0, tx_valid}, 32'd0);

        // Reset during byte 2 of SPA, then a single K.
        send(OS_SPA);
        expect_byte("spa0", 8'hBC, 1'b1, 1'b0);
        expect_byte("spa1", 8'h2C, 1'b0, 1'b0);
        check("spa2_data", {24'd0, tx_data}, 32'h0000_002C);
        rst = 1'b1;
        tick();
        check("spa_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("spa_rst_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("spa_rst_ready_after", {31'd0, req_ready}, 32'd1);
        send(OS_K);
        expect_byte("k0", 8'hBC, 1'b1, 1'b1);
        check("k_done_valid", {31'd0, tx_valid}, 32'd0);

        // NONE: accepted immediately, no bytes.
        req_os    = OS_NONE;
        req_valid = 1'b1;
        #1;
        check("none_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("none_valid", {31'd0, tx_valid}, 32'd0);
        check("none_ready_after", {31'd0, req_ready}, 32'd1);
        tick();
        check("none_valid2", {31'd0, tx_valid}, 32'd0);

        // NONE accepted on the last-byte cycle of R returns to idle.
        send(OS_R);
        req_os    = OS_NONE;
        req_valid = 1'b1;
        #1;
        expect_byte("r0", 8'h1C, 1'b1, 1'b1);
        req_valid = 1'b0;
        check("none_on_last_valid", {31'd0, tx_valid}, 32'd0);

        // Unlisted encoding behaves as length 0.
        req_os    = ordered_sets_e'(4'hF);
        req_valid = 1'b1;
        #1;
        check("bad_os_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("bad_os_valid", {31'd0, tx_valid}, 32'd0);

        // Idle continues from the LFSR state after the reset (seed reloaded).
        send(OS_A);
        expect_byte("a0", 8'h7C, 1'b1, 1'b1);
        send(OS_I);
        expect_byte("i2_0", 8'hBC, 1'b1, 1'b0);
        expect_byte("i2_1", 8'h1C, 1'b1, 1'b0);
        expect_byte("i2_2", 8'hBC, 1'b1, 1'b0);
        expect_byte("i2_3", 8'hBC, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
